// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// ---------------------------------------------------------------------------
// 640x480@60 Hz VGA raster timing generator running off the 100 MHz system
// clock. A clock divider produces a one-cycle pixel-advance strobe. The
// horizontal and vertical counters step on that strobe. Sync, visible-region
// and once-per-frame outputs are all registered.
//
// Ports
//   clk          in   system clock (100 MHz)
//   rst          in   synchronous, active-high reset
//   pix_en       out  one-clk pulse every CLK_DIV clocks (pixel advance)
//   hCount       out  horizontal pixel counter, 0..H_TOTAL-1
//   vCount       out  vertical line counter, 0..V_TOTAL-1
//   hSync        out  horizontal sync, active low
//   vSync        out  vertical sync, active low
//   bright       out  high while (hCount,vCount) is inside the visible region
//   frame_tick   out  one-clk pulse when the raster enters vertical blanking
//   frame_count  out  frames completed, wraps modulo 2^16
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int CLK_DIV     = 4,
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int H_VIS_START = 144,
    parameter int H_VIS_END   = 784,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC      = 2,
    parameter int V_VIS_START = 35,
    parameter int V_VIS_END   = 515
) (
    input  logic        clk,
    input  logic        rst,
    output logic        pix_en,
    output logic [9:0]  hCount,
    output logic [9:0]  vCount,
    output logic        hSync,
    output logic        vSync,
    output logic        bright,
    output logic        frame_tick,
    output logic [15:0] frame_count
);

    // A divide-by-one still needs a one-bit counter that simply stays at 0.
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_C  = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_C  = 10'(V_SYNC);
    localparam logic [9:0] H_VS_C    = 10'(H_VIS_START);
    localparam logic [9:0] H_VE_C    = 10'(H_VIS_END);
    localparam logic [9:0] V_VS_C    = 10'(V_VIS_START);
    localparam logic [9:0] V_VE_C    = 10'(V_VIS_END);

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_nxt;
    logic             adv;
    logic [9:0]       h_nxt;
    logic [9:0]       v_nxt;
    logic             bright_nxt;
    logic             tick_nxt;

    // Next-state: divider, raster position and the flags derived from it.
    // Sync/bright/tick are decoded from the next position so that, once
    // registered, they line up with the hCount/vCount of the same cycle.
    always_comb begin
        adv     = (div == DIV_LAST);
        div_nxt = adv ? '0 : div + DIV_W'(1);
        h_nxt   = hCount;
        v_nxt   = vCount;
        if (adv) begin
            if (hCount == H_LAST) begin
                h_nxt = '0;
                v_nxt = (vCount == V_LAST) ? '0 : vCount + 10'd1;
            end else begin
                h_nxt = hCount + 10'd1;
            end
        end
        bright_nxt = (h_nxt >= H_VS_C) && (h_nxt < H_VE_C) &&
                     (v_nxt >= V_VS_C) && (v_nxt < V_VE_C);
        // Only the advancing edge can land on (0, V_VIS_END) for the first
        // time, so gating with adv yields a single-cycle pulse.
        tick_nxt   = adv && (h_nxt == '0) && (v_nxt == V_VE_C);
    end

    // Output registers. Reset wins over everything, including a pending tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            div         <= '0;
            pix_en      <= 1'b0;
            hCount      <= '0;
            vCount      <= '0;
            hSync       <= 1'b0;   // (0,0) sits inside both sync pulses
            vSync       <= 1'b0;
            bright      <= 1'b0;
            frame_tick  <= 1'b0;
            frame_count <= '0;
        end else begin
            div        <= div_nxt;
            pix_en     <= adv;
            hCount     <= h_nxt;
            vCount     <= v_nxt;
            hSync      <= ~(h_nxt < H_SYNC_C);
            vSync      <= ~(v_nxt < V_SYNC_C);
            bright     <= bright_nxt;
            frame_tick <= tick_nxt;
            if (tick_nxt) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

endmodule
